enigma_rotor_ctrl: RTL and testbench
====================================

Name: enigma_rotor_ctrl

Overview:
Sequencer for the three-rotor 64-symbol (6-bit) Enigma datapath: rotor A, rotor B and rotor C, each with forward and backward lookups.
- Holds the rotor position registers and steps them odometer-style once per character.
- Routes wiring-table writes into the rotor tables.
- Launches one character at a time into the datapath, waits its fixed latency, and returns the ciphertext over a valid/ready handshake.
- Sits between the host character stream and the plugboard/rotor/reflector chain.

Parameters:
DP_LAT, 4, cycles from dp_char/dp_pos* valid to dp_result valid; legal range 1..15
NOTCH_A, 6'd63, rotor A position at which B is carried on the next step
NOTCH_B, 6'd63, rotor B position at which C is carried on the next step

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  wiring-table write request
cfg_rotor  in  2  target rotor: 0=A 1=B 2=C 3=reserved (write dropped)
cfg_idx  in  6  table index
cfg_data  in  6  table entry
cfg_ready  out  1  high when a write is accepted this cycle
pos_load  in  1  load initial positions
pos_init_a/b/c  in  6 each  initial positions
in_valid  in  1  plaintext character valid
in_char  in  6  plaintext
in_ready  out  1  plaintext accepted when in_valid & in_ready
out_valid  out  1  ciphertext valid
out_char  out  6  ciphertext
out_ready  in  1  downstream accepts
tbl_we  out  3  one-hot rotor table write strobe (bit0=A)
tbl_addr  out  6  table write index
tbl_data  out  6  table write data
dp_char  out  6  character driven into datapath
dp_pos_a/b/c  out  6 each  rotor offsets driven into datapath
dp_result  in  6  datapath output
busy  out  1  state != IDLE
char_cnt  out  16  characters completed, wraps at 65535->0

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following, regardless of current state:
  - state=IDLE; all positions 0; char_cnt 0.
  - out_valid=0, out_char=0, tbl_we=0, tbl_addr=0, tbl_data=0, dp_char=0.
  - An in-flight character is discarded.
- States:
  - IDLE: accepts config, position loads and characters.
  - STEP: 1 cycle.
  - WAIT: DP_LAT cycles.
  - HOLD: until handshake.
- cfg_ready = (state==IDLE) & ~pos_load.
  - An accepted write registers tbl_we/tbl_addr/tbl_data for exactly 1 cycle.
  - Writes with cfg_rotor=3 assert cfg_ready but give tbl_we=0.
  - Writes outside IDLE are not accepted and not queued.
- pos_load in IDLE: positions take pos_init_* next edge. pos_load outside IDLE is ignored.
- in_ready = (state==IDLE) & ~pos_load & ~cfg_we.
  - Priority in IDLE: pos_load > cfg_we > character.
- On accept: dp_char<=in_char, next state STEP.
- STEP, applied to the pre-step values:
  - pos_a<=pos_a+1 (mod 64, 63->0).
  - If pos_a==NOTCH_A, pos_b<=pos_b+1.
  - If pos_a==NOTCH_A and pos_b==NOTCH_B, pos_c<=pos_c+1.
  - No double-step.
  - Next state WAIT with a wait counter loaded with DP_LAT-1.
- dp_pos_* reflect the stepped positions from the cycle after STEP and stay stable through WAIT.
- WAIT: the counter decrements each cycle. At 0: out_char<=dp_result, out_valid<=1, char_cnt+1, next state HOLD.
- Character latency: in-accept edge to out_valid rising = DP_LAT+1 cycles.
- HOLD: out_char stable while out_valid=1 & out_ready=0. On out_ready, out_valid<=0 and next state IDLE. No new input accepted in HOLD (one character in flight).
- dp_char holds its value until the next accept.

Decomposition:
- Shared package enigma_pkg:
  - sym_t (6-bit symbol)
  - ALPHA=64
  - rotor id constants ROT_A/B/C
  - state enum {IDLE,STEP,WAIT,HOLD}
- One natural sub-module: enigma_rotor_stepper, holding the three position registers plus the carry/notch logic, with load/step inputs.

Test Plan:
- Reset then idle: all outputs 0, cfg_ready=1, in_ready=1, busy=0.
- Config: cfg_we, cfg_rotor=1, idx=5, data=42 -> next cycle tbl_we=3'b010, tbl_addr=5, tbl_data=42 for 1 cycle. cfg_rotor=3 -> tbl_we=0.
- Single character, stub datapath returning dp_char^6'h15, DP_LAT=4: send 6'd10 with positions 0/0/0 -> out_valid rises 5 cycles after accept, out_char=31, dp_pos_a=1, char_cnt=1.
- Carry: pos_init 63/63/7 with notches 63, one character -> positions 0/0/8. pos_init 62/63/7 -> positions 63/63/7.
- Backpressure: out_ready=0 for 10 cycles -> out_char stable, in_ready=0, busy=1. out_ready=1 -> IDLE next cycle.
- Reset mid-WAIT: rst_n low one cycle -> out_valid stays 0, positions 0, char_cnt 0, and no out_valid afterwards for the dropped character.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor sequencer and its position stepper.
package enigma_pkg;

  typedef logic [5:0] sym_t;

  localparam int ALPHA = 64;

  localparam logic [1:0] ROT_A = 2'd0;
  localparam logic [1:0] ROT_B = 2'd1;
  localparam logic [1:0] ROT_C = 2'd2;

  typedef enum logic [1:0] {IDLE, STEP, WAIT, HOLD} state_t;

  function automatic sym_t sym_inc(input sym_t s);
    return sym_t'((32'(s) + 32'd1) % ALPHA);
  endfunction

  // Reserved rotor id maps to no strobe, so the write is silently dropped.
  function automatic logic [2:0] rotor_onehot(input logic [1:0] rot);
    case (rot)
      ROT_A:   return 3'b001;
      ROT_B:   return 3'b010;
      ROT_C:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/enigma_rotor_stepper.sv
// Rotor position registers with odometer-style carry; A always steps, B and C
// carry only from the pre-step positions (no double-step).
module enigma_rotor_stepper
  import enigma_pkg::*;
#(
  parameter sym_t NOTCH_A = 6'd63,
  parameter sym_t NOTCH_B = 6'd63
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [5:0] init_a_i,
  input  logic [5:0] init_b_i,
  input  logic [5:0] init_c_i,
  output logic [5:0] pos_a_o,
  output logic [5:0] pos_b_o,
  output logic [5:0] pos_c_o
);

  sym_t pos_a_q, pos_b_q, pos_c_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pos_a_q <= '0;
      pos_b_q <= '0;
      pos_c_q <= '0;
    end else if (load_i) begin
      pos_a_q <= init_a_i;
      pos_b_q <= init_b_i;
      pos_c_q <= init_c_i;
    end else if (step_i) begin
      pos_a_q <= sym_inc(pos_a_q);
      if (pos_a_q == NOTCH_A) begin
        pos_b_q <= sym_inc(pos_b_q);
        if (pos_b_q == NOTCH_B) pos_c_q <= sym_inc(pos_c_q);
      end
    end
  end

  assign pos_a_o = pos_a_q;
  assign pos_b_o = pos_b_q;
  assign pos_c_o = pos_c_q;

endmodule

// File: rtl/enigma_rotor_ctrl.sv
// Character sequencer for the three-rotor datapath: config routing, rotor stepping,
// fixed-latency launch/capture and valid/ready return of the ciphertext.
//   state | meaning
//   IDLE  | accept position load, table write or one plaintext character
//   STEP  | advance rotor positions once
//   WAIT  | count down the datapath latency
//   HOLD  | present ciphertext until out_ready
module enigma_rotor_ctrl
  import enigma_pkg::*;
#(
  parameter int   DP_LAT  = 4,
  parameter sym_t NOTCH_A = 6'd63,
  parameter sym_t NOTCH_B = 6'd63
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_rotor_i,
  input  logic [5:0]  cfg_idx_i,
  input  logic [5:0]  cfg_data_i,
  output logic        cfg_ready_o,
  input  logic        pos_load_i,
  input  logic [5:0]  pos_init_a_i,
  input  logic [5:0]  pos_init_b_i,
  input  logic [5:0]  pos_init_c_i,
  input  logic        in_valid_i,
  input  logic [5:0]  in_char_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [5:0]  out_char_o,
  input  logic        out_ready_i,
  output logic [2:0]  tbl_we_o,
  output logic [5:0]  tbl_addr_o,
  output logic [5:0]  tbl_data_o,
  output logic [5:0]  dp_char_o,
  output logic [5:0]  dp_pos_a_o,
  output logic [5:0]  dp_pos_b_o,
  output logic [5:0]  dp_pos_c_o,
  input  logic [5:0]  dp_result_i,
  output logic        busy_o,
  output logic [15:0] char_cnt_o
);

  localparam logic [3:0] WAIT_INIT = 4'(DP_LAT - 1);

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic        out_valid_q;
  sym_t        out_char_q, dp_char_q, tbl_addr_q, tbl_data_q;
  logic [2:0]  tbl_we_q;
  logic [15:0] char_cnt_q;

  logic idle, cfg_acc, chr_acc;

  assign idle        = (state_q == IDLE);
  assign cfg_ready_o = idle & ~pos_load_i;
  assign in_ready_o  = idle & ~pos_load_i & ~cfg_we_i;
  assign cfg_acc     = cfg_ready_o & cfg_we_i;
  assign chr_acc     = in_ready_o & in_valid_i;

  enigma_rotor_stepper #(
    .NOTCH_A(NOTCH_A),
    .NOTCH_B(NOTCH_B)
  ) u_stepper (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (idle & pos_load_i),
    .step_i  (state_q == STEP),
    .init_a_i(pos_init_a_i),
    .init_b_i(pos_init_b_i),
    .init_c_i(pos_init_c_i),
    .pos_a_o (dp_pos_a_o),
    .pos_b_o (dp_pos_b_o),
    .pos_c_o (dp_pos_c_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      dp_char_q   <= '0;
      tbl_we_q    <= '0;
      tbl_addr_q  <= '0;
      tbl_data_q  <= '0;
      char_cnt_q  <= '0;
    end else begin
      tbl_we_q <= '0;
      case (state_q)
        IDLE: begin
          if (cfg_acc) begin
            tbl_we_q   <= rotor_onehot(cfg_rotor_i);
            tbl_addr_q <= cfg_idx_i;
            tbl_data_q <= cfg_data_i;
          end else if (chr_acc) begin
            dp_char_q <= in_char_i;
            state_q   <= STEP;
          end
        end
        STEP: begin
          wcnt_q  <= WAIT_INIT;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wcnt_q == 4'd0) begin
            out_char_q  <= dp_result_i;
            out_valid_q <= 1'b1;
            char_cnt_q  <= char_cnt_q + 16'd1;
            state_q     <= HOLD;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_char_o  = out_char_q;
  assign tbl_we_o    = tbl_we_q;
  assign tbl_addr_o  = tbl_addr_q;
  assign tbl_data_o  = tbl_data_q;
  assign dp_char_o   = dp_char_q;
  assign busy_o      = ~idle;
  assign char_cnt_o  = char_cnt_q;

endmodule

// File: tb/tb_enigma_rotor_ctrl.sv
// Directed bench for the rotor sequencer with a stub datapath returning dp_char ^ 6'h15.
module tb_enigma_rotor_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_rotor;
  logic [5:0]  cfg_idx, cfg_data;
  logic        cfg_ready;
  logic        pos_load;
  logic [5:0]  pos_init_a, pos_init_b, pos_init_c;
  logic        in_valid;
  logic [5:0]  in_char;
  logic        in_ready;
  logic        out_valid;
  logic [5:0]  out_char;
  logic        out_ready;
  logic [2:0]  tbl_we;
  logic [5:0]  tbl_addr, tbl_data;
  logic [5:0]  dp_char, dp_pos_a, dp_pos_b, dp_pos_c;
  logic [5:0]  dp_result;
  logic        busy;
  logic [15:0] char_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign dp_result = dp_char ^ 6'h15;

  enigma_rotor_ctrl #(.DP_LAT(4), .NOTCH_A(6'd63), .NOTCH_B(6'd63)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_rotor_i (cfg_rotor),
    .cfg_idx_i   (cfg_idx),
    .cfg_data_i  (cfg_data),
    .cfg_ready_o (cfg_ready),
    .pos_load_i  (pos_load),
    .pos_init_a_i(pos_init_a),
    .pos_init_b_i(pos_init_b),
    .pos_init_c_i(pos_init_c),
    .in_valid_i  (in_valid),
    .in_char_i   (in_char),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_char_o  (out_char),
    .out_ready_i (out_ready),
    .tbl_we_o    (tbl_we),
    .tbl_addr_o  (tbl_addr),
    .tbl_data_o  (tbl_data),
    .dp_char_o   (dp_char),
    .dp_pos_a_o  (dp_pos_a),
    .dp_pos_b_o  (dp_pos_b),
    .dp_pos_c_o  (dp_pos_c),
    .dp_result_i (dp_result),
    .busy_o      (busy),
    .char_cnt_o  (char_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_pos(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    pos_init_a = a; pos_init_b = b; pos_init_c = c;
    pos_load = 1'b1;
    tick();
    pos_load = 1'b0;
    chk("pos_loaded", {dp_pos_a, dp_pos_b, dp_pos_c}, {a, b, c});
  endtask

  // Send one char, expect out_valid DP_LAT+1 = 5 cycles after accept, then handshake.
  task automatic run_char(input string tag, input logic [5:0] ch, input logic [5:0] exp);
    int lat;
    in_char = ch; in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_out_char"}, out_char, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_rotor = '0; cfg_idx = '0; cfg_data = '0;
    pos_load = 1'b0; pos_init_a = '0; pos_init_b = '0; pos_init_c = '0;
    in_valid = 1'b0; in_char = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_tbl", {tbl_we, tbl_addr, tbl_data}, 0);
    chk("rst_dp_char", dp_char, 0);
    chk("rst_pos", {dp_pos_a, dp_pos_b, dp_pos_c}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_char_cnt", char_cnt, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 1);

    // Table write to rotor B
    cfg_we = 1'b1; cfg_rotor = 2'd1; cfg_idx = 6'd5; cfg_data = 6'd42;
    #1;
    chk("cfg_ready_wr", cfg_ready, 1);
    chk("in_ready_cfg_block", in_ready, 0);
    tick();
    cfg_we = 1'b0;
    chk("cfg_tbl_we_b", tbl_we, 3'b010);
    chk("cfg_tbl_addr", tbl_addr, 5);
    chk("cfg_tbl_data", tbl_data, 42);
    tick();
    chk("cfg_tbl_we_pulse", tbl_we, 0);

    // Reserved rotor: accepted, no strobe
    cfg_we = 1'b1; cfg_rotor = 2'd3; cfg_idx = 6'd7; cfg_data = 6'd9;
    #1;
    chk("cfg_ready_rsvd", cfg_ready, 1);
    tick();
    cfg_we = 1'b0;
    chk("cfg_tbl_we_rsvd", tbl_we, 0);

    // pos_load outranks cfg_we
    cfg_we = 1'b1; cfg_rotor = 2'd0; pos_load = 1'b1;
    pos_init_a = 6'd0; pos_init_b = 6'd0; pos_init_c = 6'd0;
    #1;
    chk("cfg_ready_posload", cfg_ready, 0);
    chk("in_ready_posload", in_ready, 0);
    tick();
    cfg_we = 1'b0; pos_load = 1'b0;
    chk("tbl_we_posload", tbl_we, 0);

    // Single character with backpressure
    in_char = 6'd10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_dp_char", dp_char, 10);
    begin
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk("single_latency", lat, 5);
    end
    chk("single_out_char", out_char, 31);
    chk("single_pos", {dp_pos_a, dp_pos_b, dp_pos_c}, {6'd1, 6'd0, 6'd0});
    chk("single_char_cnt", char_cnt, 1);
    in_valid = 1'b1; in_char = 6'd20;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_char", out_char, 31);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    chk("bp_char_cnt", char_cnt, 1);

    // Carry chain
    load_pos(6'd63, 6'd63, 6'd7);
    run_char("carry2", 6'd3, 6'd22);
    chk("carry2_pos", {dp_pos_a, dp_pos_b, dp_pos_c}, {6'd0, 6'd0, 6'd8});
    load_pos(6'd62, 6'd63, 6'd7);
    run_char("nocarry", 6'd0, 6'd21);
    chk("nocarry_pos", {dp_pos_a, dp_pos_b, dp_pos_c}, {6'd63, 6'd63, 6'd7});
    load_pos(6'd63, 6'd5, 6'd7);
    run_char("carry1", 6'd63, 6'd42);
    chk("carry1_pos", {dp_pos_a, dp_pos_b, dp_pos_c}, {6'd0, 6'd6, 6'd7});
    chk("char_cnt_4", char_cnt, 4);

    // pos_load while busy is ignored, then reset mid-WAIT drops the character
    load_pos(6'd10, 6'd20, 6'd30);
    in_char = 6'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    pos_init_a = 6'd9; pos_init_b = 6'd9; pos_init_c = 6'd9; pos_load = 1'b1;
    tick(); tick();
    pos_load = 1'b0;
    chk("busy_posload_ignored", {dp_pos_a, dp_pos_b, dp_pos_c}, {6'd11, 6'd20, 6'd30});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_pos", {dp_pos_a, dp_pos_b, dp_pos_c}, 0);
    chk("midrst_char_cnt", char_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dp_char", dp_char, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_late_valid", seen, 0);
    chk("midrst_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
